mem_port_arbiter: RTL and testbench

- Shares one 32-bit memory port between instruction fetch (pc_reg/if_id path) and the MEM stage's load/store access.
- Sequences every multi-cycle access with an ack handshake and a timeout.
- Generates the pipeline stall vector consumed by pc_reg, if_id, id_ex, ex_mem and mem_wb.
- Sits between the CPU core and the external RAM, replacing the direct rom_addr_o/rom_ce_o link.

---
 rtl/mem_port_arbiter_pkg.sv | 26 ++
 rtl/mem_port_arbiter_timeout_cnt.sv | 26 ++
 rtl/mem_port_arbiter.sv | 134 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the memory port arbiter: bus widths,
// stall encodings and arbiter state encoding.
package mem_port_arbiter_pkg;

  localparam int InstAddrW = 32;
  localparam int RegW      = 32;
  localparam int StallW    = 6;

  localparam logic ChipEnable   = 1'b1;
  localparam logic ChipDisable  = 1'b0;
  localparam logic WriteEnable  = 1'b1;
  localparam logic WriteDisable = 1'b0;

  // Stall bus bits: 0 pc, 1 if, 2 id, 3 ex, 4 mem, 5 wb
  localparam logic [StallW-1:0] StallMem = 6'b011111;
  localparam logic [StallW-1:0] StallIf  = 6'b000011;
  localparam logic [StallW-1:0] NoStall  = 6'b000000;

  typedef enum logic [1:0] {
    ArbIdle    = 2'd0,
    ArbBusyIf  = 2'd1,
    ArbBusyMem = 2'd2,
    ArbDone    = 2'd3
  } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_timeout_cnt.sv
// Busy-cycle counter; expired_o flags the last busy cycle before an abort.
module arb_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  logic [CNT_W-1:0] cnt_q;

  // Busy cycle k sees cnt_q == k-1, so the last permitted cycle has cnt_q == TIMEOUT_CYCLES-1
  assign expired_o = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      cnt_q <= '0;
    end else if (en_i && !expired_o) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares a single RAM port between instruction fetch and the MEM stage,
// with ack/timeout sequencing and pipeline stall generation.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 if_ce_i,
  input  logic [InstAddrW-1:0] if_addr_i,
  output logic [RegW-1:0]      if_data_o,
  output logic                 if_ready_o,
  input  logic                 mem_ce_i,
  input  logic                 mem_we_i,
  input  logic [3:0]           mem_sel_i,
  input  logic [RegW-1:0]      mem_addr_i,
  input  logic [RegW-1:0]      mem_wdata_i,
  output logic [RegW-1:0]      mem_rdata_o,
  output logic                 mem_ready_o,
  output logic                 ram_ce_o,
  output logic                 ram_we_o,
  output logic [3:0]           ram_sel_o,
  output logic [RegW-1:0]      ram_addr_o,
  output logic [RegW-1:0]      ram_wdata_o,
  input  logic [RegW-1:0]      ram_rdata_i,
  input  logic                 ram_ack_i,
  output logic                 err_o,
  output logic [StallW-1:0]    stall_o
);

  arb_state_e      state_q;
  logic            ram_ce_q, ram_we_q;
  logic [3:0]      ram_sel_q;
  logic [RegW-1:0] ram_addr_q, ram_wdata_q;
  logic [RegW-1:0] if_data_q, mem_rdata_q;
  logic            if_ready_q, mem_ready_q, err_q;
  logic            busy, expired;

  assign busy = (state_q == ArbBusyIf) || (state_q == ArbBusyMem);

  arb_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) u_timeout_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (!busy),
    .en_i     (busy),
    .expired_o(expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ArbIdle;
      ram_ce_q    <= ChipDisable;
      ram_we_q    <= WriteDisable;
      ram_sel_q   <= '0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      if_data_q   <= '0;
      mem_rdata_q <= '0;
      if_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      if_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
      err_q       <= 1'b0;
      unique case (state_q)
        ArbIdle: begin
          if (mem_ce_i) begin
            state_q     <= ArbBusyMem;
            ram_ce_q    <= ChipEnable;
            ram_we_q    <= mem_we_i;
            ram_sel_q   <= mem_sel_i;
            ram_addr_q  <= mem_addr_i;
            ram_wdata_q <= mem_wdata_i;
          end else if (if_ce_i) begin
            state_q    <= ArbBusyIf;
            ram_ce_q   <= ChipEnable;
            ram_we_q   <= WriteDisable;
            ram_sel_q  <= 4'hF;
            ram_addr_q <= if_addr_i;
          end
        end
        ArbBusyIf, ArbBusyMem: begin
          // A late ack beats the timeout when both land in the same cycle
          if (ram_ack_i || expired) begin
            state_q  <= ArbDone;
            ram_ce_q <= ChipDisable;
            err_q    <= !ram_ack_i;
            if (state_q == ArbBusyIf) begin
              if_ready_q <= 1'b1;
              if_data_q  <= ram_ack_i ? ram_rdata_i : '0;
            end else begin
              mem_ready_q <= 1'b1;
              if (!ram_ack_i) begin
                mem_rdata_q <= '0;
              end else if (!ram_we_q) begin
                mem_rdata_q <= ram_rdata_i;
              end
            end
          end
        end
        default: state_q <= ArbIdle;
      endcase
    end
  end

  always_comb begin
    stall_o = NoStall;
    if (rst) begin
      stall_o = NoStall;
    end else if (mem_ce_i && !mem_ready_q) begin
      stall_o = StallMem;
    end else if (if_ce_i && !if_ready_q) begin
      stall_o = StallIf;
    end
  end

  assign ram_ce_o    = ram_ce_q;
  assign ram_we_o    = ram_we_q;
  assign ram_sel_o   = ram_sel_q;
  assign ram_addr_o  = ram_addr_q;
  assign ram_wdata_o = ram_wdata_q;
  assign if_data_o   = if_data_q;
  assign if_ready_o  = if_ready_q;
  assign mem_rdata_o = mem_rdata_q;
  assign mem_ready_o = mem_ready_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, load/store, priority, timeout,
// ack-at-timeout and reset-abort scenarios.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        if_ce_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_data_o;
  logic        if_ready_o;
  logic        mem_ce_i;
  logic        mem_we_i;
  logic [3:0]  mem_sel_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_wdata_i;
  logic [31:0] mem_rdata_o;
  logic        mem_ready_o;
  logic        ram_ce_o;
  logic        ram_we_o;
  logic [3:0]  ram_sel_o;
  logic [31:0] ram_addr_o;
  logic [31:0] ram_wdata_o;
  logic [31:0] ram_rdata_i;
  logic        ram_ack_i;
  logic        err_o;
  logic [5:0]  stall_o;

  int checks = 0;
  int failures = 0;

  mem_port_arbiter #(.TIMEOUT_CYCLES(16), .CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .if_ce_i    (if_ce_i),
    .if_addr_i  (if_addr_i),
    .if_data_o  (if_data_o),
    .if_ready_o (if_ready_o),
    .mem_ce_i   (mem_ce_i),
    .mem_we_i   (mem_we_i),
    .mem_sel_i  (mem_sel_i),
    .mem_addr_i (mem_addr_i),
    .mem_wdata_i(mem_wdata_i),
    .mem_rdata_o(mem_rdata_o),
    .mem_ready_o(mem_ready_o),
    .ram_ce_o   (ram_ce_o),
    .ram_we_o   (ram_we_o),
    .ram_sel_o  (ram_sel_o),
    .ram_addr_o (ram_addr_o),
    .ram_wdata_o(ram_wdata_o),
    .ram_rdata_i(ram_rdata_i),
    .ram_ack_i  (ram_ack_i),
    .err_o      (err_o),
    .stall_o    (stall_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    if_ce_i = 1'b0; if_addr_i = '0;
    mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_sel_i = 4'h0;
    mem_addr_i = '0; mem_wdata_i = '0;
    ram_rdata_i = '0; ram_ack_i = 1'b0;

    // Reset state; stall held low even with a pending request
    tick(); tick();
    check("rst_ram_ce", ram_ce_o, 0);
    check("rst_if_ready", if_ready_o, 0);
    check("rst_mem_ready", mem_ready_o, 0);
    check("rst_err", err_o, 0);
    check("rst_stall", stall_o, 6'b000000);
    mem_ce_i = 1'b0;
    rst = 1'b0;
    tick();

    // IF-only fetch
    if_ce_i = 1'b1; if_addr_i = 32'h0000_0010;
    #1 check("if_stall_c0", stall_o, 6'b000011);
    tick();
    check("if_ram_ce", ram_ce_o, 1);
    check("if_ram_addr", ram_addr_o, 32'h0000_0010);
    check("if_ram_we", ram_we_o, 0);
    check("if_ram_sel", ram_sel_o, 4'hF);
    check("if_stall_c1", stall_o, 6'b000011);
    ram_ack_i = 1'b1; ram_rdata_i = 32'h3401_1100;
    tick();
    ram_ack_i = 1'b0;
    check("if_ready", if_ready_o, 1);
    check("if_data", if_data_o, 32'h3401_1100);
    check("if_ce_drop", ram_ce_o, 0);
    check("if_err", err_o, 0);
    if_ce_i = 1'b0;
    #1 check("if_stall_done", stall_o, 6'b000000);
    tick();
    check("if_ready_pulse", if_ready_o, 0);

    // Simultaneous requests: MEM first, IF three cycles later
    if_ce_i = 1'b1; if_addr_i = 32'h0000_0040;
    mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_sel_i = 4'hF; mem_addr_i = 32'h0000_0100;
    #1 check("pri_stall_c0", stall_o, 6'b011111);
    tick();
    check("pri_ram_addr", ram_addr_o, 32'h0000_0100);
    check("pri_ram_ce", ram_ce_o, 1);
    check("pri_ram_we", ram_we_o, 0);
    check("pri_stall_busy", stall_o, 6'b011111);
    ram_ack_i = 1'b1; ram_rdata_i = 32'hCAFE_F00D;
    tick();
    ram_ack_i = 1'b0;
    check("pri_mem_ready", mem_ready_o, 1);
    check("pri_mem_rdata", mem_rdata_o, 32'hCAFE_F00D);
    check("pri_if_ready", if_ready_o, 0);
    check("pri_stall_done", stall_o, 6'b000011);
    mem_ce_i = 1'b0;
    tick();
    check("pri_done_no_grant", ram_ce_o, 0);
    check("pri_mem_ready_pulse", mem_ready_o, 0);
    tick();
    check("pri_if_grant", ram_ce_o, 1);
    check("pri_if_addr", ram_addr_o, 32'h0000_0040);
    ram_ack_i = 1'b1; ram_rdata_i = 32'h1111_2222;
    tick();
    ram_ack_i = 1'b0;
    check("pri_if_ready", if_ready_o, 1);
    check("pri_if_data", if_data_o, 32'h1111_2222);
    if_ce_i = 1'b0;
    tick();

    // Store: outputs held until ack, load data untouched
    mem_ce_i = 1'b1; mem_we_i = 1'b1; mem_sel_i = 4'b0011;
    mem_addr_i = 32'h0000_0020; mem_wdata_i = 32'hDEAD_BEEF;
    tick();
    check("st_ram_we", ram_we_o, 1);
    check("st_ram_sel", ram_sel_o, 4'b0011);
    check("st_ram_addr", ram_addr_o, 32'h0000_0020);
    check("st_ram_wdata", ram_wdata_o, 32'hDEAD_BEEF);
    mem_wdata_i = 32'h0; mem_sel_i = 4'hF;
    tick(); tick();
    check("st_hold_ce", ram_ce_o, 1);
    check("st_hold_wdata", ram_wdata_o, 32'hDEAD_BEEF);
    check("st_hold_sel", ram_sel_o, 4'b0011);
    ram_ack_i = 1'b1; ram_rdata_i = 32'h5555_5555;
    tick();
    ram_ack_i = 1'b0;
    check("st_mem_ready", mem_ready_o, 1);
    check("st_rdata_kept", mem_rdata_o, 32'hCAFE_F00D);
    check("st_err", err_o, 0);
    mem_ce_i = 1'b0; mem_we_i = 1'b0;
    tick(); tick();

    // Timeout after 16 busy cycles without ack
    mem_ce_i = 1'b1; mem_addr_i = 32'h0000_0030;
    tick();
    for (int i = 0; i < 15; i++) tick();
    check("to_before_ce", ram_ce_o, 1);
    check("to_before_err", err_o, 0);
    check("to_before_ready", mem_ready_o, 0);
    tick();
    check("to_err", err_o, 1);
    check("to_mem_ready", mem_ready_o, 1);
    check("to_mem_rdata", mem_rdata_o, 32'h0);
    check("to_ram_ce", ram_ce_o, 0);
    mem_ce_i = 1'b0;
    tick();
    check("to_err_pulse", err_o, 0);
    check("to_ready_pulse", mem_ready_o, 0);
    tick();

    // Ack coincident with timeout: normal completion
    mem_ce_i = 1'b1; mem_addr_i = 32'h0000_0034;
    tick();
    for (int i = 0; i < 15; i++) tick();
    ram_ack_i = 1'b1; ram_rdata_i = 32'h0BAD_CAFE;
    tick();
    ram_ack_i = 1'b0;
    check("ackto_ready", mem_ready_o, 1);
    check("ackto_err", err_o, 0);
    check("ackto_rdata", mem_rdata_o, 32'h0BAD_CAFE);
    mem_ce_i = 1'b0;
    tick(); tick();

    // Reset in the middle of a fetch aborts it; later ack ignored
    if_ce_i = 1'b1; if_addr_i = 32'h0000_0050;
    tick();
    check("rstab_ce_on", ram_ce_o, 1);
    tick();
    rst = 1'b1;
    #1 check("rstab_stall", stall_o, 6'b000000);
    tick();
    check("rstab_ce_off", ram_ce_o, 0);
    check("rstab_if_ready", if_ready_o, 0);
    check("rstab_if_data", if_data_o, 32'h0);
    rst = 1'b0; if_ce_i = 1'b0;
    ram_ack_i = 1'b1; ram_rdata_i = 32'h7777_7777;
    tick();
    ram_ack_i = 1'b0;
    check("stray_if_ready", if_ready_o, 0);
    check("stray_mem_ready", mem_ready_o, 0);
    check("stray_ram_ce", ram_ce_o, 0);
    check("stray_err", err_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
